// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants, derived window origin and receiver FSM states.
package vga_timing_pkg;

  localparam int H_ACTIVE    = 640;
  localparam int H_SYNC      = 96;
  localparam int H_BACK      = 48;
  localparam int H_TOTAL     = 800;
  localparam int V_ACTIVE    = 480;
  localparam int V_SYNC      = 2;
  localparam int V_BACK      = 33;
  localparam int V_TOTAL     = 525;
  localparam int LOCK_FRAMES = 2;

  // vsync is asserted at line start, one hsync ahead of the line it belongs to, hence the -1
  localparam int H0 = H_SYNC + H_BACK;
  localparam int V0 = V_SYNC + V_BACK - 1;

  localparam logic [9:0] CNT_MAX = 10'd1023;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } rx_state_t;

  function automatic logic [9:0] sat_inc(input logic [9:0] v);
    return (v == CNT_MAX) ? v : v + 10'd1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Registers an active-low sync input and flags its falling and rising edges.
module sync_edge_detect (
  input  logic clk_25mhz,
  input  logic reset,
  input  logic sync_n,
  output logic fall,
  output logic rise
);

  logic level;
  logic level_d;

  // both stages idle high so leaving reset never looks like an edge
  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      level   <= 1'b1;
      level_d <= 1'b1;
    end else begin
      level   <= sync_n;
      level_d <= level;
    end
  end

  assign fall = level_d & ~level;
  assign rise = ~level_d & level;

endmodule

// File: rtl/vga_timing_receiver.sv
// Recovers raster position from VGA syncs, validates line/frame/sync timing and reports lock.
// state  | meaning
// SEARCH | waiting for the first vsync-aligned hsync fall
// TRACK  | counting clean frame boundaries toward lock
// LOCKED | timing verified, active window and frame_start enabled
module vga_timing_receiver #(
  parameter int H_ACTIVE    = vga_timing_pkg::H_ACTIVE,
  parameter int H_SYNC      = vga_timing_pkg::H_SYNC,
  parameter int H_BACK      = vga_timing_pkg::H_BACK,
  parameter int H_TOTAL     = vga_timing_pkg::H_TOTAL,
  parameter int V_ACTIVE    = vga_timing_pkg::V_ACTIVE,
  parameter int V_SYNC      = vga_timing_pkg::V_SYNC,
  parameter int V_BACK      = vga_timing_pkg::V_BACK,
  parameter int V_TOTAL     = vga_timing_pkg::V_TOTAL,
  parameter int LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES
) (
  input  logic       clk_25mhz,
  input  logic       reset,
  input  logic       h_sync,
  input  logic       v_sync,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_active,
  output logic       frame_start,
  output logic       locked,
  output logic       timing_error,
  output logic [9:0] line_len,
  output logic [9:0] frame_lines
);
  import vga_timing_pkg::*;

  localparam int GW = $clog2(LOCK_FRAMES + 1);

  localparam logic [9:0] H_START     = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_END       = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0] V_START     = 10'(V_SYNC + V_BACK - 1);
  localparam logic [9:0] V_END       = 10'(V_SYNC + V_BACK - 1 + V_ACTIVE);
  localparam logic [9:0] H_TOTAL_L   = 10'(H_TOTAL);
  localparam logic [9:0] V_TOTAL_L   = 10'(V_TOTAL);
  localparam logic [9:0] H_SYNC_L    = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_LAST = 10'(V_SYNC - 1);
  localparam logic [GW-1:0] GOOD_LOCK = GW'(LOCK_FRAMES);

  logic          hs_fall, hs_rise, vs_fall, vs_rise, vs_aligned;
  logic [9:0]    hpos_reg, vpos_reg, hpos, vpos;
  logic          vs_pend, primed, check_fail, loss, in_window;
  rx_state_t     state, state_nx;
  logic [GW-1:0] good, good_nx;

  sync_edge_detect u_hs_edge (
    .clk_25mhz (clk_25mhz),
    .reset     (reset),
    .sync_n    (h_sync),
    .fall      (hs_fall),
    .rise      (hs_rise)
  );

  sync_edge_detect u_vs_edge (
    .clk_25mhz (clk_25mhz),
    .reset     (reset),
    .sync_n    (v_sync),
    .fall      (vs_fall),
    .rise      (vs_rise)
  );

  assign vs_aligned = hs_fall && (vs_pend || vs_fall);

  // hpos_reg still holds the finished line's length during the fall cycle
  always_comb begin
    hpos = hpos_reg;
    vpos = vpos_reg;
    if (hs_fall) begin
      hpos = '0;
      vpos = vs_aligned ? '0 : sat_inc(vpos_reg);
    end
  end

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      hpos_reg    <= CNT_MAX;
      vpos_reg    <= CNT_MAX;
      vs_pend     <= 1'b0;
      primed      <= 1'b0;
      line_len    <= '0;
      frame_lines <= '0;
    end else begin
      hpos_reg <= sat_inc(hpos);
      vpos_reg <= vpos;
      primed   <= primed | hs_fall;
      if (vs_aligned) begin
        vs_pend <= 1'b0;
      end else if (vs_fall) begin
        vs_pend <= 1'b1;
      end
      if (hs_fall) begin
        line_len <= hpos_reg;
      end
      if (vs_aligned) begin
        frame_lines <= vpos_reg + 10'd1;
      end
    end
  end

  assign check_fail = primed && (
      (hs_fall    && (hpos_reg != H_TOTAL_L)) ||
      (hs_rise    && (hpos != H_SYNC_L)) ||
      (vs_aligned && ((vpos_reg + 10'd1) != V_TOTAL_L)) ||
      (vs_rise    && (vpos != V_SYNC_LAST)));

  assign loss = (hpos == CNT_MAX) || (vpos == CNT_MAX);

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      state <= SEARCH;
      good  <= '0;
    end else begin
      state <= state_nx;
      good  <= good_nx;
    end
  end

  // SEARCH never pulses, so a saturated counter reports its loss exactly once
  always_comb begin
    state_nx     = state;
    good_nx      = good;
    timing_error = 1'b0;
    case (state)
      SEARCH: begin
        if (vs_aligned) begin
          state_nx = TRACK;
          good_nx  = '0;
        end
      end
      TRACK, LOCKED: begin
        if (loss) begin
          state_nx     = SEARCH;
          good_nx      = '0;
          timing_error = 1'b1;
        end else if (check_fail) begin
          state_nx     = TRACK;
          good_nx      = '0;
          timing_error = 1'b1;
        end else if (vs_aligned && (state == TRACK)) begin
          good_nx = good + GW'(1);
          if (good_nx == GOOD_LOCK) begin
            state_nx = LOCKED;
          end
        end
      end
      default: begin
        state_nx = SEARCH;
        good_nx  = '0;
      end
    endcase
  end

  always_comb begin
    in_window    = (hpos >= H_START) && (hpos < H_END) &&
                   (vpos >= V_START) && (vpos < V_END);
    locked       = (state == LOCKED);
    video_active = locked && in_window;
    pixel_x      = '0;
    pixel_y      = '0;
    if (video_active) begin
      pixel_x = hpos - H_START;
      pixel_y = vpos - V_START;
    end
    frame_start  = video_active && (hpos == H_START) && (vpos == V_START);
  end

endmodule

// File: doc/vga_timing_receiver.md
Name: vga_timing_receiver

Overview:
- Sink-side counterpart of the 640x480@60 VGA timing generator.
- Samples active-low h_sync/v_sync on the pixel clock and recovers hpos/vpos, pixel_x/pixel_y and a video_active window.
- Checks line length, frame length and sync widths against the VGA constants, and reports lock and errors.
- Used for loopback self-test of the video path and as the front end of a future capture path.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_SYNC, 96, hsync width in clocks
- H_BACK, 48, horizontal back porch
- H_TOTAL, 800, clocks per line
- V_ACTIVE, 480, active lines per frame
- V_SYNC, 2, vsync width in lines
- V_BACK, 33, vertical back porch
- V_TOTAL, 525, lines per frame
- LOCK_FRAMES, 2, consecutive clean frames required to assert locked

Ports:
- clk_25mhz  in  1  pixel clock (one clock domain; reset is asynchronous, active-high)
- reset  in  1  asynchronous active-high reset
- h_sync  in  1  active-low horizontal sync, synchronous to clk_25mhz
- v_sync  in  1  active-low vertical sync, synchronous to clk_25mhz
- pixel_x  out  10  column 0..H_ACTIVE-1 when video_active, else 0
- pixel_y  out  10  row 0..V_ACTIVE-1 when video_active, else 0
- video_active  out  1  locked AND inside the active window
- frame_start  out  1  one-cycle pulse on pixel (0,0) while locked
- locked  out  1  timing verified
- timing_error  out  1  one-cycle pulse per detected violation
- line_len  out  10  last measured clocks between hsync falls
- frame_lines  out  10  last measured lines between vsync-aligned line starts

Behaviour:
- Input register: s_hs and s_vs each pass through 1 flop, reset to 1 (idle) so reset creates no false edge. A fall is s_d=1, s=0; a rise is s_d=0, s=1.
- hpos (10b): equals 0 in the hs-fall cycle, then increments each clock and saturates at 1023. hpos_reg reads as the measured line length in the fall cycle.
- vpos (10b): a vs fall sets vs_pend. At the next hs fall, vpos=0 and vs_pend clears; any other hs fall increments vpos, saturating at 1023.
- Window: H0 = H_SYNC+H_BACK (144) and V0 = V_SYNC+V_BACK-1 (34). The -1 exists because the transmitter asserts vsync at line start, ahead of hsync.
- Active: H0 <= hpos < H0+H_ACTIVE and V0 <= vpos < V0+V_ACTIVE. Then pixel_x = hpos-H0 and pixel_y = vpos-V0.
- Latency: the decode is combinational from registered counters. Outputs lag the transmitter's internal counters by exactly 1 clock.
- Checks (skipped before the first hs fall after reset):
  - at hs fall: hpos_reg == H_TOTAL;
  - at hs rise: hpos == H_SYNC;
  - at vs-aligned hs fall: vpos_reg+1 == V_TOTAL;
  - at vs rise: vpos == V_SYNC-1.
- line_len is updated at every hs fall. frame_lines is updated at every vs-aligned hs fall.
- FSM states SEARCH, TRACK, LOCKED:
  - SEARCH → TRACK (good=0) at the first vs-aligned hs fall.
  - TRACK: a clean frame boundary increments good; good == LOCK_FRAMES → LOCKED.
  - Any failed check in TRACK or LOCKED → TRACK with good=0, locked=0, and a 1-cycle timing_error pulse.
  - Simultaneous failures in the same cycle produce a single pulse.
- Loss: hpos or vpos reaching 1023 → SEARCH, locked=0, one timing_error pulse. No repeat pulse while saturated.
- Reset (asynchronous, mid-frame included):
  - hpos=vpos=1023, state SEARCH, vs_pend=0, good=0;
  - all outputs 0, with line_len=frame_lines=0.
- Width rule: H_TOTAL and V_TOTAL must be < 1023. All arithmetic is 10-bit unsigned.

Decomposition:
- Package vga_timing_pkg: the 640x480 constants shared with the generator, the H0/V0 derived localparams, and the FSM state enum.
- Sub-module sync_edge_detect (sample flop plus rise/fall pulses), instantiated twice.

Test Plan:
- Generator loopback from reset → locked rises at the 2nd clean frame boundary after the first vs-aligned hs fall. line_len=800, frame_lines=525, and no timing_error for 10 frames.
- Locked loopback → exactly 307200 video_active cycles per frame. (0,0) appears 1 clock after generator h=0,v=0, and (639,479) is the last active pixel. frame_start pulses once per frame.
- One 801-clock line → a single timing_error at that hs fall and locked drops. locked returns after 2 clean frames.
- hsync width 95 → timing_error at the rise cycle; line_len stays 800.
- h_sync held high → timing_error once when hpos hits 1023. State is SEARCH, video_active=0, and no further pulses.
- reset asserted mid-line → all outputs 0 immediately. Re-lock follows the same frame-count rule as the first scenario.
